// File: rtl/wbus_arb.sv
// Two-master write-bus arbiter with single-entry holding registers.
// Round-robin or fixed-priority grant onto one registered dmem write port.
module wbus_arb #(
   parameter int unsigned RR_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_wr,
   input  logic [31:0] m0_waddr,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_wdata,
   output logic        m0_ready,
   input  logic        m1_wr,
   input  logic [31:0] m1_waddr,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_wdata,
   output logic        m1_ready,
   output logic        dmem_wr,
   output logic [31:0] dmem_waddr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   output logic        dmem_gnt
);

   logic        full0_q, full0_d;
   logic        full1_q, full1_d;
   logic [31:0] addr0_q, addr0_d;
   logic [31:0] addr1_q, addr1_d;
   logic [3:0]  strb0_q, strb0_d;
   logic [3:0]  strb1_q, strb1_d;
   logic [31:0] data0_q, data0_d;
   logic [31:0] data1_q, data1_d;
   logic        last_gnt_q, last_gnt_d;
   logic        dmem_wr_q, dmem_wr_d;
   logic [31:0] dmem_waddr_q, dmem_waddr_d;
   logic [3:0]  dmem_wstrb_q, dmem_wstrb_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic        dmem_gnt_q, dmem_gnt_d;

   logic acc0, acc1, issue, sel1;

   always_comb begin
      acc0  = m0_wr & ~full0_q;
      acc1  = m1_wr & ~full1_q;
      issue = full0_q | full1_q;
      if (full0_q && full1_q) begin
         sel1 = (RR_EN != 0) ? ~last_gnt_q : 1'b0;
      end else begin
         sel1 = full1_q;
      end

      // A holding register is never accepted and issued on the same edge
      full0_d = acc0 | (full0_q & ~(issue & ~sel1));
      full1_d = acc1 | (full1_q & ~(issue & sel1));

      addr0_d = acc0 ? m0_waddr : addr0_q;
      strb0_d = acc0 ? m0_wstrb : strb0_q;
      data0_d = acc0 ? m0_wdata : data0_q;
      addr1_d = acc1 ? m1_waddr : addr1_q;
      strb1_d = acc1 ? m1_wstrb : strb1_q;
      data1_d = acc1 ? m1_wdata : data1_q;

      dmem_wr_d    = issue;
      dmem_waddr_d = dmem_waddr_q;
      dmem_wstrb_d = dmem_wstrb_q;
      dmem_wdata_d = dmem_wdata_q;
      dmem_gnt_d   = dmem_gnt_q;
      last_gnt_d   = last_gnt_q;
      if (issue) begin
         dmem_waddr_d = sel1 ? addr1_q : addr0_q;
         dmem_wstrb_d = sel1 ? strb1_q : strb0_q;
         dmem_wdata_d = sel1 ? data1_q : data0_q;
         dmem_gnt_d   = sel1;
         last_gnt_d   = sel1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full0_q      <= 1'b0;
         full1_q      <= 1'b0;
         addr0_q      <= '0;
         addr1_q      <= '0;
         strb0_q      <= '0;
         strb1_q      <= '0;
         data0_q      <= '0;
         data1_q      <= '0;
         last_gnt_q   <= 1'b1;
         dmem_wr_q    <= 1'b0;
         dmem_waddr_q <= '0;
         dmem_wstrb_q <= '0;
         dmem_wdata_q <= '0;
         dmem_gnt_q   <= 1'b0;
      end else begin
         full0_q      <= full0_d;
         full1_q      <= full1_d;
         addr0_q      <= addr0_d;
         addr1_q      <= addr1_d;
         strb0_q      <= strb0_d;
         strb1_q      <= strb1_d;
         data0_q      <= data0_d;
         data1_q      <= data1_d;
         last_gnt_q   <= last_gnt_d;
         dmem_wr_q    <= dmem_wr_d;
         dmem_waddr_q <= dmem_waddr_d;
         dmem_wstrb_q <= dmem_wstrb_d;
         dmem_wdata_q <= dmem_wdata_d;
         dmem_gnt_q   <= dmem_gnt_d;
      end
   end

   assign m0_ready   = ~full0_q;
   assign m1_ready   = ~full1_q;
   assign dmem_wr    = dmem_wr_q;
   assign dmem_waddr = dmem_waddr_q;
   assign dmem_wstrb = dmem_wstrb_q;
   assign dmem_wdata = dmem_wdata_q;
   assign dmem_gnt   = dmem_gnt_q;

endmodule

// File: tb/tb_wbus_arb.sv
// Directed bench for wbus_arb: round-robin and fixed-priority instances.
module tb_wbus_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        r0_wr, r1_wr, r0_rdy, r1_rdy;
   logic [31:0] r0_addr, r1_addr, r0_data, r1_data;
   logic [3:0]  r0_strb, r1_strb;
   logic        rd_wr, rd_gnt;
   logic [31:0] rd_addr, rd_data;
   logic [3:0]  rd_strb;

   logic        f0_wr, f1_wr, f0_rdy, f1_rdy;
   logic [31:0] f0_addr, f1_addr, f0_data, f1_data;
   logic [3:0]  f0_strb, f1_strb;
   logic        fd_wr, fd_gnt;
   logic [31:0] fd_addr, fd_data;
   logic [3:0]  fd_strb;

   wbus_arb #(.RR_EN(1)) u_rr (
      .clk(clk), .rst(rst),
      .m0_wr(r0_wr), .m0_waddr(r0_addr), .m0_wstrb(r0_strb),
      .m0_wdata(r0_data), .m0_ready(r0_rdy),
      .m1_wr(r1_wr), .m1_waddr(r1_addr), .m1_wstrb(r1_strb),
      .m1_wdata(r1_data), .m1_ready(r1_rdy),
      .dmem_wr(rd_wr), .dmem_waddr(rd_addr), .dmem_wstrb(rd_strb),
      .dmem_wdata(rd_data), .dmem_gnt(rd_gnt)
   );

   wbus_arb #(.RR_EN(0)) u_fp (
      .clk(clk), .rst(rst),
      .m0_wr(f0_wr), .m0_waddr(f0_addr), .m0_wstrb(f0_strb),
      .m0_wdata(f0_data), .m0_ready(f0_rdy),
      .m1_wr(f1_wr), .m1_waddr(f1_addr), .m1_wstrb(f1_strb),
      .m1_wdata(f1_data), .m1_ready(f1_rdy),
      .dmem_wr(fd_wr), .dmem_waddr(fd_addr), .dmem_wstrb(fd_strb),
      .dmem_wdata(fd_data), .dmem_gnt(fd_gnt)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   logic        eg;
   logic [31:0] ed;
   int          m1_cnt;

   initial begin
      rst = 1'b1;
      {r0_wr, r1_wr, f0_wr, f1_wr} = '0;
      {r0_addr, r1_addr, f0_addr, f1_addr} = '0;
      {r0_strb, r1_strb, f0_strb, f1_strb} = '0;
      {r0_data, r1_data, f0_data, f1_data} = '0;
      step;
      step;
      chk("rst_rdy0", r0_rdy, 1);
      chk("rst_rdy1", r1_rdy, 1);
      chk("rst_wr", rd_wr, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_strb", rd_strb, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_gnt", rd_gnt, 0);
      rst = 1'b0;

      // contention right after reset: m0 must win first
      r0_wr = 1; r0_addr = 32'h10; r0_strb = 4'h3; r0_data = 32'h11;
      r1_wr = 1; r1_addr = 32'h20; r1_strb = 4'hC; r1_data = 32'h22;
      step;
      r0_wr = 0; r1_wr = 0;
      chk("ct_rdy0", r0_rdy, 0);
      chk("ct_rdy1", r1_rdy, 0);
      chk("ct_wr0", rd_wr, 0);
      step;
      chk("ct_a_wr", rd_wr, 1);
      chk("ct_a_data", rd_data, 32'h11);
      chk("ct_a_addr", rd_addr, 32'h10);
      chk("ct_a_strb", rd_strb, 4'h3);
      chk("ct_a_gnt", rd_gnt, 0);
      chk("ct_a_rdy0", r0_rdy, 1);
      step;
      chk("ct_b_wr", rd_wr, 1);
      chk("ct_b_data", rd_data, 32'h22);
      chk("ct_b_strb", rd_strb, 4'hC);
      chk("ct_b_gnt", rd_gnt, 1);
      chk("ct_b_rdy1", r1_rdy, 1);
      step;
      chk("ct_idle_wr", rd_wr, 0);
      chk("ct_hold_data", rd_data, 32'h22);
      chk("ct_hold_gnt", rd_gnt, 1);

      // single uncontended write
      r0_wr = 1; r0_addr = 32'h0100_0004; r0_strb = 4'hF;
      r0_data = 32'hDEADBEEF;
      step;
      r0_wr = 0;
      chk("sw_rdy_low", r0_rdy, 0);
      chk("sw_wr_early", rd_wr, 0);
      step;
      chk("sw_wr", rd_wr, 1);
      chk("sw_addr", rd_addr, 32'h0100_0004);
      chk("sw_strb", rd_strb, 4'hF);
      chk("sw_data", rd_data, 32'hDEADBEEF);
      chk("sw_gnt", rd_gnt, 0);
      chk("sw_rdy_back", r0_rdy, 1);
      step;
      chk("sw_pulse", rd_wr, 0);
      chk("sw_hold", rd_data, 32'hDEADBEEF);

      // sustained requests; last grant was m0, so m1 goes first
      for (int n = 0; n <= 10; n++) begin
         r0_wr = 1; r0_data = 32'hA000_0000 | n;
         r1_wr = 1; r1_data = 32'hB000_0000 | n;
         step;
         if (n == 0) begin
            chk("rr_n0_wr", rd_wr, 0);
         end else begin
            eg = n[0];
            ed = (n < 3) ? 32'h0 : 32'(n - 1);
            ed = ed | (eg ? 32'hB000_0000 : 32'hA000_0000);
            chk("rr_wr", rd_wr, 1);
            chk("rr_gnt", rd_gnt, eg);
            chk("rr_data", rd_data, ed);
         end
      end
      r0_wr = 0; r1_wr = 0;
      step;
      chk("rr_drain_gnt", rd_gnt, 1);
      chk("rr_drain_data", rd_data, 32'hB000_000A);
      step;
      chk("rr_drain_idle", rd_wr, 0);

      // back-pressure: data changed while m1 not ready is ignored
      r1_wr = 1; r1_data = 32'hC0;
      step;
      r1_data = 32'hC1;
      step;
      chk("bp_wr0", rd_wr, 1);
      chk("bp_data0", rd_data, 32'hC0);
      r1_data = 32'hC2;
      step;
      chk("bp_idle", rd_wr, 0);
      chk("bp_hold", rd_data, 32'hC0);
      r1_data = 32'hC3;
      step;
      r1_wr = 0;
      chk("bp_wr2", rd_wr, 1);
      chk("bp_data2", rd_data, 32'hC2);
      step;
      chk("bp_end", rd_wr, 0);
      chk("bp_end_data", rd_data, 32'hC2);

      // reset while both holding registers are busy
      r0_wr = 1; r0_data = 32'h55; r1_wr = 1; r1_data = 32'h66;
      step;
      r0_wr = 0; r1_wr = 0;
      step;
      chk("mr_pre_wr", rd_wr, 1);
      rst = 1'b1;
      #1;
      chk("mr_async_wr", rd_wr, 0);
      chk("mr_rdy0", r0_rdy, 1);
      chk("mr_rdy1", r1_rdy, 1);
      chk("mr_data", rd_data, 0);
      step;
      rst = 1'b0;
      step;
      chk("mr_no_issue", rd_wr, 0);
      step;
      chk("mr_no_issue2", rd_wr, 0);
      r0_wr = 1; r0_data = 32'h77; r1_wr = 1; r1_data = 32'h88;
      step;
      r0_wr = 0; r1_wr = 0;
      step;
      chk("mr_ct_gnt", rd_gnt, 0);
      chk("mr_ct_data", rd_data, 32'h77);
      step;
      chk("mr_ct_gnt2", rd_gnt, 1);
      chk("mr_ct_data2", rd_data, 32'h88);
      step;

      // fixed priority: m0 wins contention even right after an m0 grant
      f0_wr = 1; f0_data = 32'h33;
      step;
      f0_wr = 0;
      step;
      chk("fp_sw_gnt", fd_gnt, 0);
      chk("fp_sw_data", fd_data, 32'h33);
      step;
      f0_wr = 1; f0_data = 32'h44; f1_wr = 1; f1_data = 32'h45;
      step;
      f0_wr = 0; f1_wr = 0;
      step;
      chk("fp_ct_gnt", fd_gnt, 0);
      chk("fp_ct_data", fd_data, 32'h44);
      step;
      chk("fp_ct_gnt2", fd_gnt, 1);
      chk("fp_ct_data2", fd_data, 32'h45);
      step;
      chk("fp_ct_idle", fd_wr, 0);

      // fixed priority under sustained requests from both masters
      m1_cnt = 0;
      for (int n = 0; n < 100; n++) begin
         f0_wr = 1; f0_data = 32'hA000_0000 | n;
         f1_wr = 1; f1_data = 32'hB000_0000 | n;
         step;
         if (n == 0) begin
            chk("fp_n0_wr", fd_wr, 0);
         end else begin
            eg = ~n[0];
            ed = (n < 3) ? 32'h0 : 32'(n - 1);
            ed = ed | (eg ? 32'hB000_0000 : 32'hA000_0000);
            chk("fp_wr", fd_wr, 1);
            chk("fp_gnt", fd_gnt, eg);
            chk("fp_data", fd_data, ed);
            if (fd_wr && fd_gnt) m1_cnt++;
         end
      end
      f0_wr = 0; f1_wr = 0;
      step;
      chk("fp_drain_gnt", fd_gnt, 1);
      chk("fp_drain_data", fd_data, 32'hB000_0063);
      if (fd_wr && fd_gnt) m1_cnt++;
      step;
      chk("fp_drain_idle", fd_wr, 0);
      chk("fp_m1_count", m1_cnt, 50);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/wbus_arb.md
WBUS_ARB -- requirements
Module: wbus_arb

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with master 0 highest.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-004 The block SHALL have port m0_wr, input, 1 bit, master 0 write request, qualified by m0_ready.
REQ-005 The block SHALL have port m0_waddr, input, 32 bits, master 0 byte address.
REQ-006 The block SHALL have port m0_wstrb, input, 4 bits, master 0 byte strobes.
REQ-007 The block SHALL have port m0_wdata, input, 32 bits, master 0 write data.
REQ-008 The block SHALL have port m0_ready, output, 1 bit, high when the master 0 holding register is empty.
REQ-009 The block SHALL have ports m1_wr, m1_waddr, m1_wstrb, m1_wdata and m1_ready for master 1, with the same directions, widths and meanings as the master 0 ports.
REQ-010 The block SHALL have port dmem_wr, output, 1 bit, a one-cycle write pulse to the downstream address decoders.
REQ-011 The block SHALL have port dmem_waddr, output, 32 bits, the granted write address.
REQ-012 The block SHALL have port dmem_wstrb, output, 4 bits, the granted byte strobes.
REQ-013 The block SHALL have port dmem_wdata, output, 32 bits, the granted write data.
REQ-014 The block SHALL have port dmem_gnt, output, 1 bit, the index of the master that owns the current dmem write.

Function
REQ-015 Accept: when mN_wr=1 and mN_ready=1 at a rising edge, the block SHALL capture addr, strb and data into holding register N and set fullN=1.
REQ-016 The block SHALL ignore mN_wr while mN_ready=0, with no capture and no error.
REQ-017 mN_ready SHALL equal ~fullN, driven from a register with no combinational path from any input.
REQ-018 Arbitration: at each rising edge where at least one fullN=1, the block SHALL select exactly one master.
REQ-019 When only one fullN=1, that master SHALL be selected.
REQ-020 When both are full and RR_EN=1, the master other than last_gnt SHALL be selected.
REQ-021 When both are full and RR_EN=0, master 0 SHALL be selected.
REQ-022 Issue: on the selecting edge, the block SHALL register the selected entry onto dmem_waddr, dmem_wstrb and dmem_wdata.
REQ-023 On the selecting edge, the block SHALL set dmem_wr=1, dmem_gnt=index and last_gnt=index, and clear the selected fullN.
REQ-024 dmem_wr SHALL be high for exactly one cycle per issued entry.
REQ-025 When neither fullN=1 at an edge, dmem_wr SHALL be 0 in the following cycle.
REQ-026 When dmem_wr=0, dmem_waddr, dmem_wstrb, dmem_wdata and dmem_gnt SHALL hold their last issued values.
REQ-027 Latency: a request accepted at edge k SHALL produce dmem_wr=1 in the cycle after edge k+1 when uncontended, and mN_ready SHALL be 1 again in that same cycle.
REQ-028 Contention: the losing entry SHALL issue on the next edge, so with both masters busy dmem_wr SHALL be high every cycle, alternating masters under RR_EN=1.
REQ-029 Simultaneous events: a new accept on master N SHALL NOT occur on the edge where entry N is issued, because mN_ready is 0 at that edge.
REQ-030 Simultaneous accepts on master 0 and master 1 at the same edge SHALL both be captured.
REQ-031 Ordering: entries from one master SHALL issue in acceptance order; each holding register has depth one.
REQ-032 Entries SHALL NOT be dropped, duplicated or merged, and the contents issued on dmem_* SHALL be the captured contents unaltered.
REQ-033 The block SHALL NOT perform address decode; sel and address masking remain in the downstream decoders.

Reset
REQ-034 While rst=1, the block SHALL hold full0=0, full1=0, m0_ready=1, m1_ready=1 and dmem_wr=0.
REQ-035 While rst=1, the block SHALL hold dmem_waddr=0, dmem_wstrb=0, dmem_wdata=0, dmem_gnt=0 and last_gnt=1, so master 0 wins the first contention.
REQ-036 Reset asserted mid-operation SHALL discard pending holding-register entries and SHALL force dmem_wr low immediately, asynchronously.
REQ-037 After rst deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-038 Single write: m0_wr=1, addr=0x0100_0004, strb=0xF, data=0xDEADBEEF for one cycle -> dmem_wr=1 exactly 2 edges later with those values and dmem_gnt=0; m0_ready is 0 for one cycle.
REQ-039 Contention with RR_EN=1: both masters request at the same edge (m0 data=0x11, m1 data=0x22) -> consecutive dmem_wr cycles carry 0x11 with gnt=0, then 0x22 with gnt=1.
REQ-040 Fairness under sustained requests: both masters request every cycle their ready is high -> dmem_gnt alternates 0,1,0,1 and dmem_wr stays high continuously.
REQ-041 Fixed priority with RR_EN=0: m0 and m1 both always requesting -> m1 issues only in cycles when full0=0; no m1 entry is lost over 100 cycles.
REQ-042 Back-pressure: m1_wr held high with changing data while m1_ready=0 -> only the values captured at ready edges appear on dmem_wdata.
REQ-043 Reset mid-flight: rst pulsed with full0=1 and full1=1 -> no dmem_wr issues afterwards, both ready signals are 1, and the next contention grants m0.
